audio_sample_fifo: RTL and testbench

- Elastic buffer between the monitor-link packet decoder and the I2S sender.
- Stores 32-bit stereo audio samples (L=[31:16], R=[15:0]) that arrive in bursts on mon_clk.
- Issues request ticks to the outbound sender so the host refills the buffer.
- Serves one sample per I2S frame request, with 22 kHz sample doubling and start/end-of-stream sequencing.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/sample_ram.sv | 27 ++
 rtl/audio_sample_fifo.sv | 188 ++++++++++++++++++
 tb/tb_audio_sample_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample FIFO: the playback state
// enum, the sample width and the left/right channel field positions.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int SAMPLE_W  = 32;
    localparam int LEFT_MSB  = 31;
    localparam int LEFT_LSB  = 16;
    localparam int RIGHT_MSB = 15;
    localparam int RIGHT_LSB = 0;

    function automatic logic [SAMPLE_W-1:0] make_sample(input logic [15:0] left,
                                                        input logic [15:0] right);
        return {left, right};
    endfunction

endpackage

// File: rtl/sample_ram.sv
// DEPTH x 32 sample storage: one synchronous write port, one asynchronous
// read port so the parent can present the FIFO head combinationally.
module sample_ram
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [SAMPLE_W-1:0] wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [SAMPLE_W-1:0] rdata_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/audio_sample_fifo.sv
// Elastic stereo sample buffer between the monitor-link decoder and the I2S
// sender. Build option AUDIO_FIFO_HOLD_LAST_EN: underruns replay the last sample.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int BURST       = 4,
    parameter int START_LEVEL = 8
) (
    input  logic                mon_clk,
    input  logic                reset,
    input  logic                wr_valid,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                audio_starts,
    input  logic                end_audio_sample,
    input  logic                audio_22khz,
    input  logic                rd_req,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_valid,
    output logic                request_mode,
    output logic                request_tick,
    output logic [AW:0]         level,
    output logic                underrun,
    output logic                overflow
);

    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [AW:0] TICK_MAX  = LW'(DEPTH - BURST);
    localparam logic [AW:0] START_LVL = LW'(START_LEVEL);
    localparam logic [AW:0] BURST_LVL = LW'(BURST);

    state_e              state_q, state_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         outstanding_q, outstanding_d;
    logic [AW:0]         level_w;
    logic                dup_q, dup_d, dup_eff, prev_22k_q;
    logic                request_mode_q, request_mode_d;
    logic                request_tick_q, request_tick_d;
    logic                rd_valid_q, underrun_q, underrun_d, overflow_q, overflow_d;
    logic [SAMPLE_W-1:0] rd_data_q, rd_data_d, head_w, underrun_data_w;
    logic                empty_w, full_w, streaming_w, serving_w;
    logic                pop_w, push_w, wr_ok_w;

    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (mon_clk),
        .we_i    (push_w),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head_w)
    );

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    logic [SAMPLE_W-1:0] last_q;

    always_ff @(posedge mon_clk) begin
        if (reset || audio_starts) begin
            last_q <= '0;
        end else if (pop_w) begin
            last_q <= head_w;
        end
    end

    assign underrun_data_w = last_q;
`else
    assign underrun_data_w = '0;
`endif

    // FSM: state register
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; a new stream start overrides everything else
    always_comb begin
        state_d = state_q;
        if (audio_starts) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                FILL:  if (end_audio_sample)         state_d = DRAIN;
                       else if (level_w >= START_LVL) state_d = PLAY;
                PLAY:  if (end_audio_sample)         state_d = DRAIN;
                DRAIN: if (empty_w && !rd_req)       state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: state-derived outputs
    always_comb begin
        streaming_w    = (state_q == FILL) || (state_q == PLAY);
        request_mode_d = streaming_w;
    end

    always_comb begin
        level_w   = wr_ptr_q - rd_ptr_q;
        empty_w   = (level_w == '0);
        full_w    = (level_w == FULL_LVL);
        serving_w = rd_req && ((state_q == PLAY) || (state_q == DRAIN));

        // A rate change invalidates the duplicate phase for the current request too
        dup_eff = dup_q && (audio_22khz == prev_22k_q);
        pop_w   = serving_w && !empty_w && (!audio_22khz || dup_eff);

        wr_ok_w    = wr_valid && (state_q != IDLE) && !audio_starts;
        push_w     = wr_ok_w && (!full_w || pop_w);
        overflow_d = wr_ok_w && full_w && !pop_w;

        request_tick_d = streaming_w && (outstanding_q == '0) &&
                         (level_w <= TICK_MAX) && !audio_starts;

        outstanding_d = outstanding_q;
        wr_ptr_d      = wr_ptr_q + LW'(push_w);
        rd_ptr_d      = rd_ptr_q + LW'(pop_w);
        dup_d         = (serving_w && !empty_w && audio_22khz) ? !dup_eff : dup_eff;
        if (audio_starts) begin
            outstanding_d = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            dup_d         = 1'b0;
        end else if (request_tick_d) begin
            outstanding_d = BURST_LVL;
        end else if (push_w && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - LW'(1);
        end

        rd_data_d  = '0;
        underrun_d = 1'b0;
        if (serving_w) begin
            if (!empty_w) begin
                rd_data_d = head_w;
            end else if (state_q == PLAY) begin
                rd_data_d  = underrun_data_w;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            outstanding_q  <= '0;
            dup_q          <= 1'b0;
            prev_22k_q     <= 1'b0;
            request_mode_q <= 1'b0;
            request_tick_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            underrun_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            outstanding_q  <= outstanding_d;
            dup_q          <= dup_d;
            prev_22k_q     <= audio_22khz;
            request_mode_q <= request_mode_d;
            request_tick_q <= request_tick_d;
            rd_valid_q     <= rd_req;
            underrun_q     <= underrun_d;
            overflow_q     <= overflow_d;
            if (rd_req) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign request_mode = request_mode_q;
    assign request_tick = request_tick_q;
    assign level        = level_w;
    assign underrun     = underrun_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: stream start, fill/play, 22 kHz
// doubling, overflow, underrun, drain and mid-stream restart/reset.
module tb_audio_sample_fifo;

    logic        mon_clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        audio_starts;
    logic        end_audio_sample;
    logic        audio_22khz;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        request_mode;
    logic        request_tick;
    logic [4:0]  level;
    logic        underrun;
    logic        overflow;

    int checks   = 0;
    int errors   = 0;
    int tick_cnt = 0;
    int tick_base;

`ifdef AUDIO_FIFO_HOLD_LAST_EN
    localparam logic [31:0] UNDER_EXP = 32'h0008_0008;
`else
    localparam logic [31:0] UNDER_EXP = 32'h0000_0000;
`endif

    always #5 mon_clk = ~mon_clk;

    always @(negedge mon_clk) begin
        if (request_tick) tick_cnt++;
    end

    audio_sample_fifo #(
        .DEPTH       (16),
        .AW          (4),
        .BURST       (4),
        .START_LEVEL (8)
    ) dut (
        .mon_clk          (mon_clk),
        .reset            (reset),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .audio_starts     (audio_starts),
        .end_audio_sample (end_audio_sample),
        .audio_22khz      (audio_22khz),
        .rd_req           (rd_req),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .request_mode     (request_mode),
        .request_tick     (request_tick),
        .level            (level),
        .underrun         (underrun),
        .overflow         (overflow)
    );

    task automatic cyc();
        @(posedge mon_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic write_s(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
        $display("write data=%08h level=%0d overflow=%0b", d, level, overflow);
    endtask

    task automatic read_s(input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        $display("read  data=%08h valid=%0b level=%0d underrun=%0b", rd_data, rd_valid, level, underrun);
        check({tag, "_valid"}, 32'(rd_valid), 32'h1);
        check(tag, rd_data, exp);
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; audio_starts = 1'b0;
        end_audio_sample = 1'b0; audio_22khz = 1'b0; rd_req = 1'b0;
        cyc();
        cyc();
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_req_mode", 32'(request_mode), 32'h0);
        check("rst_tick", 32'(request_tick), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_flags", {30'b0, underrun, overflow}, 32'h0);
        reset = 1'b0;

        // Stream start: request_mode and the first tick appear two edges later
        audio_starts = 1'b1;
        cyc();
        audio_starts = 1'b0;
        check("start_mode_early", 32'(request_mode), 32'h0);
        cyc();
        check("start_mode", 32'(request_mode), 32'h1);
        check("start_tick", 32'(request_tick), 32'h1);
        cyc();
        check("start_tick_once", 32'(request_tick), 32'h0);

        for (int k = 1; k <= 4; k++) write_s(32'h0001_0001 * 32'(k));
        check("fill_level4", 32'(level), 32'd4);
        check("fill_no_tick", 32'(request_tick), 32'h0);
        cyc();
        check("second_tick", 32'(request_tick), 32'h1);
        for (int k = 5; k <= 8; k++) write_s(32'h0001_0001 * 32'(k));
        check("fill_level8", 32'(level), 32'd8);

        // Still FILL on this edge: read returns zero and pops nothing
        read_s("fill_read", 32'h0);
        check("fill_read_level", 32'(level), 32'd8);

        for (int k = 1; k <= 8; k++) read_s("play44", 32'h0001_0001 * 32'(k));
        check("play44_level", 32'(level), 32'd0);
        cyc();
        check("rd_valid_pulse", 32'(rd_valid), 32'h0);

        read_s("underrun_data", UNDER_EXP);
        check("underrun_flag", 32'(underrun), 32'h1);
        cyc();
        check("underrun_pulse", 32'(underrun), 32'h0);

        // 22 kHz doubling
        audio_22khz = 1'b1;
        write_s(32'hAAAA_1111);
        write_s(32'hBBBB_2222);
        read_s("dbl_1", 32'hAAAA_1111);
        check("dbl_1_level", 32'(level), 32'd2);
        read_s("dbl_2", 32'hAAAA_1111);
        check("dbl_2_level", 32'(level), 32'd1);
        read_s("dbl_3", 32'hBBBB_2222);
        check("dbl_3_level", 32'(level), 32'd1);
        read_s("dbl_4", 32'hBBBB_2222);
        check("dbl_4_level", 32'(level), 32'd0);
        audio_22khz = 1'b0;
        cyc();

        // Overflow
        for (int k = 0; k < 16; k++) write_s(32'h1000_0000 + 32'(k));
        check("full_level", 32'(level), 32'd16);
        check("full_no_ovf", 32'(overflow), 32'h0);
        write_s(32'hDEAD_BEEF);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_level", 32'(level), 32'd16);
        cyc();
        check("ovf_pulse", 32'(overflow), 32'h0);
        wr_valid = 1'b1; wr_data = 32'h2000_0000; rd_req = 1'b1;
        cyc();
        wr_valid = 1'b0; rd_req = 1'b0;
        $display("rdwr  data=%08h valid=%0b level=%0d overflow=%0b", rd_data, rd_valid, level, overflow);
        check("full_rw_data", rd_data, 32'h1000_0000);
        check("full_rw_level", 32'(level), 32'd16);
        check("full_rw_no_ovf", 32'(overflow), 32'h0);

        for (int k = 0; k < 13; k++) read_s("pre_drain", 32'h1000_0001 + 32'(k));
        check("pre_drain_level", 32'(level), 32'd3);

        // Drain the last three samples, then IDLE
        end_audio_sample = 1'b1;
        cyc();
        end_audio_sample = 1'b0;
        cyc();
        check("drain_mode", 32'(request_mode), 32'h0);
        tick_base = tick_cnt;
        read_s("drain_1", 32'h1000_000E);
        read_s("drain_2", 32'h1000_000F);
        read_s("drain_3", 32'h2000_0000);
        check("drain_level", 32'(level), 32'd0);
        read_s("drain_empty", 32'h0);
        check("drain_no_underrun", 32'(underrun), 32'h0);
        cyc();
        write_s(32'h1234_5678);
        check("idle_write_ignored", 32'(level), 32'd0);
        cyc();
        check("drain_no_ticks", 32'(tick_cnt - tick_base), 32'h0);

        // Restart while draining flushes and re-enters FILL
        audio_starts = 1'b1;
        cyc();
        audio_starts = 1'b0;
        for (int k = 0; k < 3; k++) write_s(32'h3000_0000 + 32'(k));
        check("refill_level", 32'(level), 32'd3);
        end_audio_sample = 1'b1;
        cyc();
        end_audio_sample = 1'b0;
        cyc();
        check("drain2_mode", 32'(request_mode), 32'h0);
        audio_starts = 1'b1;
        cyc();
        audio_starts = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        cyc();
        check("flush_mode", 32'(request_mode), 32'h1);
        read_s("flush_fill_read", 32'h0);

        // Reset mid-stream discards contents
        write_s(32'h4000_0000);
        check("pre_reset_level", 32'(level), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_reset_level", 32'(level), 32'd0);
        check("mid_reset_mode", 32'(request_mode), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
